fp16_normalize_round: RTL and testbench

Pipelined normalize-and-round stage for the half-precision datapath. Sits directly downstream of the FP16 multiplier: consumes the raw significand product, exponent sum and special-case flags, and produces a packed IEEE-754 binary16 result with round-to-nearest-even. Uses a valid/ready handshake, a two-stage pipeline and sticky exception flags.

---
 rtl/fp16_pkg.sv | 31 +++
 rtl/fp16_normalize_round_if.sv | 33 +++
 rtl/fp16_round_rne.sv | 15 +
 rtl/fp16_normalize_round.sv | 164 ++++++++++++++++
 tb/tb_fp16_normalize_round.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared definitions for the FP16 normalize-and-round stage.
package fp16_pkg;

  localparam int unsigned BIAS    = 15;
  localparam int unsigned EXP_MAX = 31;
  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] INF     = 16'h7C00;

  // Bit positions inside the {overflow, underflow, inexact} flag vector.
  localparam int unsigned FLAG_OVF = 2;
  localparam int unsigned FLAG_UNF = 1;
  localparam int unsigned FLAG_INX = 0;

  // Upstream special-case classification, already priority-resolved.
  typedef enum logic [1:0] {
    KIND_NUM  = 2'd0,
    KIND_ZERO = 2'd1,
    KIND_INF  = 2'd2,
    KIND_NAN  = 2'd3
  } kind_e;

  // Stage-1 register: normalized significand with the leading one at bit 20.
  typedef struct packed {
    logic        sign;
    logic [6:0]  exp;
    logic [20:0] sig;
    logic        sticky;
    kind_e       kind;
  } s1_t;

endpackage

// File: rtl/fp16_normalize_round_if.sv
// Handshake bundle for fp16_normalize_round.
// Both channels use valid/ready: a beat transfers on a rising clock edge where
// valid and ready are both high; a producer holding valid must keep its data
// stable until that edge, and ready never depends on the same side's valid.
interface fp16_normalize_round_if;
  logic        io_in_valid;
  logic        io_in_ready;
  logic        io_in_sign;
  logic [6:0]  io_in_exponent;
  logic [21:0] io_in_mantissa;
  logic        io_in_is_nan;
  logic        io_in_is_inf;
  logic        io_in_is_zero;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [15:0] io_out_data;
  logic [2:0]  io_flags;
  logic        io_flags_clear;

  // Environment side: feeds operands, consumes results.
  modport master (
    output io_in_valid, io_in_sign, io_in_exponent, io_in_mantissa,
           io_in_is_nan, io_in_is_inf, io_in_is_zero, io_out_ready, io_flags_clear,
    input  io_in_ready, io_out_valid, io_out_data, io_flags
  );

  // Stage side.
  modport slave (
    input  io_in_valid, io_in_sign, io_in_exponent, io_in_mantissa,
           io_in_is_nan, io_in_is_inf, io_in_is_zero, io_out_ready, io_flags_clear,
    output io_in_ready, io_out_valid, io_out_data, io_flags
  );
endinterface

// File: rtl/fp16_round_rne.sv
// Round-to-nearest-even on a 10-bit fraction given guard and sticky bits.
module fp16_round_rne (
  input  logic [9:0] frac_i,
  input  logic       guard_i,
  input  logic       sticky_i,
  output logic [9:0] frac_o,
  output logic       carry_o,
  output logic       inexact_o
);
  logic round_up;

  assign round_up  = guard_i & (sticky_i | frac_i[0]);
  assign {carry_o, frac_o} = {1'b0, frac_i} + {10'd0, round_up};
  assign inexact_o = guard_i | sticky_i;
endmodule

// File: rtl/fp16_normalize_round.sv
// Two-stage normalize and round-to-nearest-even pack to IEEE binary16.
// Optional feature macro: FP16_SUBNORMAL_EN (gradual underflow); when it is
// undefined, tiny results flush to signed zero.
module fp16_normalize_round
  import fp16_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  fp16_normalize_round_if.slave io
);
  logic        adv;
  logic        s1_valid_q;
  s1_t         s1_d, s1_q;
  logic        out_valid_q;
  logic [15:0] out_data_q;
  logic [2:0]  out_flags_q;
  logic [2:0]  flags_d, flags_q;
  logic [15:0] res_data;
  logic [2:0]  res_flags;

  logic signed [7:0] e2;
  logic        tiny;
  logic [9:0]  rnd_frac_in;
  logic        rnd_guard, rnd_sticky;
  logic [9:0]  rnd_frac;
  logic        rnd_carry, rnd_inexact;
  logic [7:0]  e_fin;
`ifdef FP16_SUBNORMAL_EN
  logic [7:0]  shamt;
  logic [3:0]  sh;
  logic [19:0] shifted;
  logic        lost;
  logic        big_shift;
`endif

  // Both stages move together; a held output freezes the whole pipe.
  assign adv            = io.io_out_ready | ~out_valid_q;
  assign io.io_in_ready = adv;
  assign io.io_out_valid = out_valid_q;
  assign io.io_out_data  = out_data_q;
  assign io.io_flags     = flags_q;

  // Stage 1: classify specials and bring the leading one to bit 20.
  always_comb begin
    s1_d        = '0;
    s1_d.sign   = io.io_in_sign;
    if (io.io_in_is_nan)       s1_d.kind = KIND_NAN;
    else if (io.io_in_is_inf)  s1_d.kind = KIND_INF;
    else if (io.io_in_is_zero) s1_d.kind = KIND_ZERO;
    else                       s1_d.kind = KIND_NUM;
    if (io.io_in_mantissa[21]) begin
      s1_d.sig    = io.io_in_mantissa[21:1];
      s1_d.exp    = io.io_in_exponent + 7'd1;
      s1_d.sticky = io.io_in_mantissa[0];
    end else begin
      s1_d.sig    = io.io_in_mantissa[20:0];
      s1_d.exp    = io.io_in_exponent;
      s1_d.sticky = 1'b0;
    end
  end

  // Stage 2 rounder inputs: normal field split, or denormalizing shift when tiny.
  always_comb begin
    e2          = {s1_q.exp[6], s1_q.exp};
    tiny        = (e2 <= 8'sd0);
    rnd_frac_in = s1_q.sig[19:10];
    rnd_guard   = s1_q.sig[9];
    rnd_sticky  = (|s1_q.sig[8:0]) | s1_q.sticky;
`ifdef FP16_SUBNORMAL_EN
    shamt     = 8'd1 - e2;
    big_shift = (shamt >= 8'd12);
    sh        = shamt[3:0];
    // Shift amount is at least 1 here, so bit 20 always leaves the top field.
    shifted   = s1_q.sig[20:1] >> (sh - 4'd1);
    lost      = |(s1_q.sig & ((21'h1 << sh) - 21'h1));
    if (tiny && !big_shift) begin
      rnd_frac_in = shifted[19:10];
      rnd_guard   = shifted[9];
      rnd_sticky  = (|shifted[8:0]) | lost | s1_q.sticky;
    end
`endif
  end

  fp16_round_rne u_round (
    .frac_i    (rnd_frac_in),
    .guard_i   (rnd_guard),
    .sticky_i  (rnd_sticky),
    .frac_o    (rnd_frac),
    .carry_o   (rnd_carry),
    .inexact_o (rnd_inexact)
  );

  // Stage 2 result: specials bypass, then overflow, tiny and normal packing.
  always_comb begin
    res_data  = '0;
    res_flags = '0;
    e_fin     = e2 + {7'd0, rnd_carry};
    unique case (s1_q.kind)
      KIND_NAN:  res_data = QNAN;
      KIND_INF:  res_data = {s1_q.sign, INF[14:0]};
      KIND_ZERO: res_data = {s1_q.sign, 15'h0};
      default: begin
        if (s1_q.sig == '0) begin
          res_data = {s1_q.sign, 15'h0};
        end else if (tiny) begin
`ifdef FP16_SUBNORMAL_EN
          if (big_shift) begin
            res_data            = {s1_q.sign, 15'h0};
            res_flags[FLAG_UNF] = 1'b1;
            res_flags[FLAG_INX] = 1'b1;
          end else begin
            // A carry out of the fraction promotes to the smallest normal.
            res_data            = {s1_q.sign, 4'd0, rnd_carry, rnd_frac};
            res_flags[FLAG_UNF] = rnd_inexact;
            res_flags[FLAG_INX] = rnd_inexact;
          end
`else
          res_data            = {s1_q.sign, 15'h0};
          res_flags[FLAG_UNF] = 1'b1;
          res_flags[FLAG_INX] = 1'b1;
`endif
        end else if (e_fin >= 8'(EXP_MAX)) begin
          res_data            = {s1_q.sign, INF[14:0]};
          res_flags[FLAG_OVF] = 1'b1;
          res_flags[FLAG_INX] = 1'b1;
        end else begin
          res_data            = {s1_q.sign, e_fin[4:0], rnd_frac};
          res_flags[FLAG_INX] = rnd_inexact;
        end
      end
    endcase
  end

  // Pipeline registers; contents only change when the pipe advances.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else if (adv) begin
      s1_valid_q  <= io.io_in_valid;
      if (io.io_in_valid) s1_q <= s1_d;
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q  <= res_data;
        out_flags_q <= res_flags;
      end
    end
  end

  // Sticky flags: clear first, then OR in the departing beat so a set wins.
  always_comb begin
    flags_d = io.io_flags_clear ? 3'b000 : flags_q;
    if (out_valid_q && io.io_out_ready) flags_d = flags_d | out_flags_q;
  end

  // Flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end
endmodule

// File: tb/tb_fp16_normalize_round.sv
// Directed bench for fp16_normalize_round.
module tb_fp16_normalize_round;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fp16_normalize_round_if bus ();

  fp16_normalize_round dut (
    .clock (clk),
    .reset (rst),
    .io    (bus)
  );

  // Clock and initial driver values.
  always #5 clk = ~clk;

  initial begin
    bus.io_in_valid    = 1'b0;
    bus.io_in_sign     = 1'b0;
    bus.io_in_exponent = '0;
    bus.io_in_mantissa = '0;
    bus.io_in_is_nan   = 1'b0;
    bus.io_in_is_inf   = 1'b0;
    bus.io_in_is_zero  = 1'b0;
    bus.io_out_ready   = 1'b1;
    bus.io_flags_clear = 1'b0;
  end

  // Driver: clear flags, send one beat, wait (bounded) for its result and flags.
  task automatic run_beat(input logic s, input logic [6:0] e, input logic [21:0] m,
                          input logic nan, input logic inf, input logic zero,
                          output logic [15:0] d, output logic [2:0] f, output int lat);
    @(negedge clk);
    bus.io_flags_clear = 1'b1;
    bus.io_out_ready   = 1'b1;
    @(negedge clk);
    bus.io_flags_clear = 1'b0;
    bus.io_in_sign     = s;
    bus.io_in_exponent = e;
    bus.io_in_mantissa = m;
    bus.io_in_is_nan   = nan;
    bus.io_in_is_inf   = inf;
    bus.io_in_is_zero  = zero;
    bus.io_in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.io_in_valid = 1'b0;
    bus.io_in_is_nan  = 1'b0;
    bus.io_in_is_inf  = 1'b0;
    bus.io_in_is_zero = 1'b0;
    lat = 1;
    while (!bus.io_out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.io_out_valid) begin
      d   = 'x;
      f   = 'x;
      lat = 99;
    end else begin
      d = bus.io_out_data;
      @(negedge clk);
      f = bus.io_flags;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.io_out_valid !== 1'b0 || bus.io_out_data !== 16'h0000 || bus.io_flags !== 3'b000) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h f=%b want v=0 d=0000 f=000",
               bus.io_out_valid, bus.io_out_data, bus.io_flags);
    end
    checks++;
    if (bus.io_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus.io_in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_normalize();
    logic [15:0] d;
    logic [2:0]  f;
    int          lat;
    run_beat(1'b0, 7'd15, 22'h240000, 1'b0, 1'b0, 1'b0, d, f, lat);
    checks++;
    if (d !== 16'h4080) begin errors++; $display("FAIL normalize_data got %h want 4080", d); end
    checks++;
    if (f !== 3'b000) begin errors++; $display("FAIL normalize_flags got %b want 000", f); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL normalize_latency got %0d want 2", lat); end
  endtask

  task automatic test_round();
    logic [21:0] m_t [6] = '{22'h100200, 22'h100600, 22'h100201, 22'h1FFE00, 22'h200001, 22'h100400};
    logic [15:0] d_t [6] = '{16'h3C00, 16'h3C02, 16'h3C01, 16'h4000, 16'h4000, 16'h3C01};
    logic [2:0]  f_t [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    logic [15:0] d;
    logic [2:0]  f;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_beat(1'b0, 7'd15, m_t[i], 1'b0, 1'b0, 1'b0, d, f, lat);
      checks++;
      if (d !== d_t[i] || f !== f_t[i]) begin
        errors++;
        $display("FAIL round_%0d mant=%h got d=%h f=%b want d=%h f=%b", i, m_t[i], d, f, d_t[i], f_t[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic        s_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [6:0]  e_t [4] = '{7'd31, 7'd31, 7'd30, 7'd30};
    logic [21:0] m_t [4] = '{22'h100000, 22'h100000, 22'h1FFE00, 22'h100000};
    logic [15:0] d_t [4] = '{16'h7C00, 16'hFC00, 16'h7C00, 16'h7800};
    logic [2:0]  f_t [4] = '{3'b101, 3'b101, 3'b101, 3'b000};
    logic [15:0] d;
    logic [2:0]  f;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_beat(s_t[i], e_t[i], m_t[i], 1'b0, 1'b0, 1'b0, d, f, lat);
      checks++;
      if (d !== d_t[i] || f !== f_t[i]) begin
        errors++;
        $display("FAIL overflow_%0d got d=%h f=%b want d=%h f=%b", i, d, f, d_t[i], f_t[i]);
      end
    end
  endtask

  task automatic test_underflow();
`ifdef FP16_SUBNORMAL_EN
    logic [15:0] d_t [5] = '{16'h0400, 16'h8000, 16'h0200, 16'h0400, 16'h0001};
    logic [2:0]  f_t [5] = '{3'b000, 3'b011, 3'b000, 3'b011, 3'b000};
`else
    logic [15:0] d_t [5] = '{16'h0400, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
    logic [2:0]  f_t [5] = '{3'b000, 3'b011, 3'b011, 3'b011, 3'b011};
`endif
    logic        s_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [6:0]  e_t [5] = '{7'd1, 7'h75, 7'd0, 7'd0, 7'h77};
    logic [21:0] m_t [5] = '{22'h100000, 22'h100000, 22'h100000, 22'h1FFF00, 22'h100000};
    logic [15:0] d;
    logic [2:0]  f;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_beat(s_t[i], e_t[i], m_t[i], 1'b0, 1'b0, 1'b0, d, f, lat);
      checks++;
      if (d !== d_t[i] || f !== f_t[i]) begin
        errors++;
        $display("FAIL underflow_%0d got d=%h f=%b want d=%h f=%b", i, d, f, d_t[i], f_t[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic        s_t [3] = '{1'b0, 1'b1, 1'b1};
    logic        n_t [3] = '{1'b1, 1'b0, 1'b0};
    logic        i_t [3] = '{1'b1, 1'b0, 1'b1};
    logic        z_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] d_t [3] = '{16'h7E00, 16'h8000, 16'hFC00};
    logic [15:0] d;
    logic [2:0]  f;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      run_beat(s_t[i], 7'd31, 22'h1FFE00, n_t[i], i_t[i], z_t[i], d, f, lat);
      checks++;
      if (d !== d_t[i] || f !== 3'b000) begin
        errors++;
        $display("FAIL special_%0d got d=%h f=%b want d=%h f=000", i, d, f, d_t[i]);
      end
    end
  endtask

  // Five beats streamed with the consumer stalling for three cycles mid-stream.
  task automatic test_backpressure();
    logic [15:0] exp_q[$];
    logic [15:0] got, prev_data;
    logic        prev_stall;
    logic        saw_ready_low;
    int          sent, recv;
    sent = 0;
    recv = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    saw_ready_low = 1'b0;
    bus.io_in_sign = 1'b0;
    bus.io_in_exponent = 7'd15;
    for (int c = 0; c < 40 && recv < 5; c++) begin
      @(negedge clk);
      bus.io_out_ready = !(c >= 4 && c <= 6);
      bus.io_in_valid  = (sent < 5);
      bus.io_in_mantissa = 22'h100000 | (22'(sent + 1) << 10);
      #1;
      if (prev_stall) begin
        checks++;
        if (bus.io_out_data !== prev_data) begin
          errors++;
          $display("FAIL bp_hold cycle %0d got %h want %h", c, bus.io_out_data, prev_data);
        end
      end
      if (bus.io_out_valid && !bus.io_out_ready) begin
        checks++;
        if (bus.io_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready cycle %0d got %b want 0", c, bus.io_in_ready);
        end else saw_ready_low = 1'b1;
      end
      if (bus.io_out_valid && bus.io_out_ready) begin
        got = bus.io_out_data;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra_beat got %h want none", got);
        end else begin
          prev_data = exp_q.pop_front();
          if (got !== prev_data) begin
            errors++;
            $display("FAIL bp_order beat %0d got %h want %h", recv, got, prev_data);
          end
        end
        recv++;
      end
      if (bus.io_in_valid && bus.io_in_ready) begin
        exp_q.push_back(16'h3C00 + 16'(sent + 1));
        sent++;
      end
      prev_stall = bus.io_out_valid && !bus.io_out_ready;
      prev_data  = bus.io_out_data;
    end
    @(negedge clk);
    bus.io_in_valid  = 1'b0;
    bus.io_out_ready = 1'b1;
    checks++;
    if (recv !== 5) begin errors++; $display("FAIL bp_count got %0d want 5", recv); end
    checks++;
    if (saw_ready_low !== 1'b1) begin errors++; $display("FAIL bp_stall_seen got 0 want 1"); end
  endtask

  // Reset mid-stream clears the output and flags without waiting for a clock edge.
  task automatic test_reset_midstream();
    logic [15:0] d;
    logic [2:0]  f;
    int          lat;
    run_beat(1'b0, 7'd31, 22'h100000, 1'b0, 1'b0, 1'b0, d, f, lat);
    checks++;
    if (f !== 3'b101) begin errors++; $display("FAIL rst_pre_flags got %b want 101", f); end
    bus.io_out_ready   = 1'b0;
    bus.io_in_exponent = 7'd15;
    bus.io_in_mantissa = 22'h100400;
    bus.io_in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.io_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.io_out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", bus.io_out_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.io_out_valid !== 1'b0 || bus.io_flags !== 3'b000 || bus.io_out_data !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid got v=%b f=%b d=%h want v=0 f=000 d=0000",
               bus.io_out_valid, bus.io_flags, bus.io_out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.io_out_ready = 1'b1;
    run_beat(1'b0, 7'd15, 22'h100600, 1'b0, 1'b0, 1'b0, d, f, lat);
    checks++;
    if (d !== 16'h3C02 || f !== 3'b001) begin
      errors++;
      $display("FAIL rst_recover got d=%h f=%b want d=3c02 f=001", d, f);
    end
  endtask

  // Flag accumulation across beats, and clear colliding with a flag-setting beat.
  task automatic test_flags_sticky();
    @(negedge clk);
    bus.io_flags_clear = 1'b1;
    @(negedge clk);
    bus.io_flags_clear = 1'b0;
    bus.io_in_exponent = 7'd31;
    bus.io_in_mantissa = 22'h100000;
    bus.io_in_valid    = 1'b1;
    @(negedge clk);
    bus.io_in_exponent = 7'd15;
    bus.io_in_mantissa = 22'h100000;
    @(negedge clk);
    bus.io_in_valid = 1'b0;
    // Overflow beat is now in the output register and leaves at the next edge.
    bus.io_flags_clear = 1'b1;
    @(negedge clk);
    bus.io_flags_clear = 1'b0;
    checks++;
    if (bus.io_flags !== 3'b101) begin
      errors++;
      $display("FAIL flags_clear_vs_set got %b want 101", bus.io_flags);
    end
    @(negedge clk);
    checks++;
    if (bus.io_flags !== 3'b101) begin
      errors++;
      $display("FAIL flags_sticky got %b want 101", bus.io_flags);
    end
  endtask

  initial begin
    test_reset();
    test_normalize();
    test_round();
    test_overflow();
    test_underflow();
    test_specials();
    test_flags_sticky();
    test_backpressure();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
